float_to_int_arbiter: RTL and testbench

//   Shares one float-to-int conversion datapath among N_REQ AXI-Stream requesters.

---
 rtl/float_to_int_arbiter.sv | 129 ++++++++++++
 tb/tb_float_to_int_arbiter.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/float_to_int_arbiter.sv
// Round-robin arbiter sharing one float-to-int (truncating) converter among N_REQ AXI-Stream requesters.
// Optional define FTOI_SATURATE_EN: NaN -> 0, out-of-range/Inf saturate to INT32 limits.
module float_to_int_arbiter #(
    parameter int unsigned N_REQ = 4,
    parameter int unsigned ID_W  = 2,
    parameter int unsigned CNT_W = 16
) (
    input  logic                 aclk,
    input  logic                 aresetn,
    input  logic [N_REQ*32-1:0]  s_axis_tdata,
    input  logic [N_REQ-1:0]     s_axis_tvalid,
    output logic [N_REQ-1:0]     s_axis_tready,
    output logic [31:0]          m_axis_tdata,
    output logic [ID_W-1:0]      m_axis_tid,
    output logic                 m_axis_tvalid,
    input  logic                 m_axis_tready,
    output logic                 busy,
    output logic [CNT_W-1:0]     done_count
);

    localparam int unsigned IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    typedef enum logic [1:0] {IDLE, CONV, OUT} state_t;

    state_t           state;
    logic [IDX_W-1:0] rr_ptr;
    logic [IDX_W-1:0] grant_idx;
    logic [IDX_W-1:0] winner;
    logic             any_valid;
    logic [31:0]      sel_data;
    logic [31:0]      float_q;
    logic [31:0]      conv_result;

    // First valid requester at or after rr_ptr, searching cyclically
    always_comb begin
        int unsigned idx;
        idx       = 0;
        winner    = '0;
        any_valid = 1'b0;
        sel_data  = '0;
        for (int unsigned k = 0; k < N_REQ; k++) begin
            idx = (32'(rr_ptr) + k) % N_REQ;
            if (!any_valid && s_axis_tvalid[idx]) begin
                any_valid = 1'b1;
                winner    = IDX_W'(idx);
                sel_data  = s_axis_tdata[32*idx +: 32];
            end
        end
    end

    always_comb begin
        s_axis_tready = '0;
        for (int unsigned k = 0; k < N_REQ; k++) begin
            s_axis_tready[k] = aresetn && (state == IDLE) && any_valid && (winner == IDX_W'(k));
        end
    end

    // Truncating conversion of the latched float
    always_comb begin
        logic [7:0]  exp_f;
        logic [7:0]  lsh;
        logic [7:0]  rsh;
        logic [31:0] base;
        logic [31:0] mag;
        exp_f = float_q[30:23];
        base  = {8'd0, 1'b1, float_q[22:0]};
        lsh   = exp_f - 8'd150;
        rsh   = 8'd150 - exp_f;
        mag   = '0;
        if (exp_f >= 8'd150) begin
            mag = (lsh >= 8'd32) ? 32'd0 : (base << lsh[4:0]);
        end else if (exp_f >= 8'd127) begin
            mag = base >> rsh[4:0];
        end
        conv_result = float_q[31] ? (32'd0 - mag) : mag;
`ifdef FTOI_SATURATE_EN
        if (exp_f == 8'hFF && float_q[22:0] != 23'd0) begin
            conv_result = '0;
        end else if (exp_f >= 8'd158) begin
            conv_result = float_q[31] ? 32'h8000_0000 : 32'h7FFF_FFFF;
        end
`endif
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state         <= IDLE;
            rr_ptr        <= '0;
            grant_idx     <= '0;
            float_q       <= '0;
            m_axis_tdata  <= '0;
            m_axis_tid    <= '0;
            m_axis_tvalid <= 1'b0;
            busy          <= 1'b0;
            done_count    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (any_valid) begin
                        float_q   <= sel_data;
                        grant_idx <= winner;
                        busy      <= 1'b1;
                        state     <= CONV;
                    end
                end
                CONV: begin
                    m_axis_tdata  <= conv_result;
                    m_axis_tid    <= ID_W'(grant_idx);
                    m_axis_tvalid <= 1'b1;
                    state         <= OUT;
                end
                OUT: begin
                    if (m_axis_tready) begin
                        m_axis_tvalid <= 1'b0;
                        rr_ptr        <= (grant_idx == IDX_W'(N_REQ - 1)) ? '0 : IDX_W'(grant_idx + 1'b1);
                        done_count    <= done_count + 1'b1;
                        busy          <= 1'b0;
                        state         <= IDLE;
                    end
                end
                default: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_float_to_int_arbiter.sv
// Scoreboard bench for float_to_int_arbiter: directed cases plus randomized traffic against a behavioural model.
module tb_float_to_int_arbiter;

    localparam int unsigned N_REQ = 4;
    localparam int unsigned ID_W  = 2;
    localparam int unsigned CNT_W = 16;

    logic                aclk = 1'b0;
    logic                aresetn;
    logic [N_REQ*32-1:0] s_axis_tdata;
    logic [N_REQ-1:0]    s_axis_tvalid;
    logic [N_REQ-1:0]    s_axis_tready;
    logic [31:0]         m_axis_tdata;
    logic [ID_W-1:0]     m_axis_tid;
    logic                m_axis_tvalid;
    logic                m_axis_tready;
    logic                busy;
    logic [CNT_W-1:0]    done_count;

    int n_checks = 0;
    int n_pass   = 0;

    typedef struct {
        int          id;
        logic [31:0] data;
    } exp_t;

    exp_t sb_q[$];
    int   rr_model  = 0;
    int   cnt_model = 0;
    bit   in_flight = 1'b0;
    int   since_hs  = 0;

    always #5 aclk = ~aclk;

    float_to_int_arbiter #(.N_REQ(N_REQ), .ID_W(ID_W), .CNT_W(CNT_W)) dut (
        .aclk          (aclk),
        .aresetn       (aresetn),
        .s_axis_tdata  (s_axis_tdata),
        .s_axis_tvalid (s_axis_tvalid),
        .s_axis_tready (s_axis_tready),
        .m_axis_tdata  (m_axis_tdata),
        .m_axis_tid    (m_axis_tid),
        .m_axis_tvalid (m_axis_tvalid),
        .m_axis_tready (m_axis_tready),
        .busy          (busy),
        .done_count    (done_count)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    endtask

    // Value-level model: truncate sign*(1.m)*2^(e-127) toward zero, keep low 32 bits
    function automatic logic [31:0] ref_conv(input logic [31:0] f);
        int     e;
        longint mant;
        longint mag;
        e    = int'(f[30:23]);
        mant = longint'({1'b1, f[22:0]});
`ifdef FTOI_SATURATE_EN
        if (e == 255 && f[22:0] != 23'd0) return 32'd0;
        if (e >= 158) return f[31] ? 32'h8000_0000 : 32'h7FFF_FFFF;
`endif
        if (e < 127) mag = 0;
        else if (e < 150) mag = mant / (longint'(1) << (150 - e));
        else begin
            mag = mant;
            for (int k = 0; k < e - 150; k++) mag = (mag * 2) % (longint'(1) << 32);
        end
        return f[31] ? 32'(-mag) : 32'(mag);
    endfunction

    function automatic logic [31:0] rand_float();
        logic [7:0] e;
        case ($urandom_range(0, 3))
            0:       e = 8'($urandom_range(120, 160));
            1:       e = 8'($urandom_range(0, 255));
            2:       e = 8'($urandom_range(150, 165));
            default: e = 8'($urandom_range(126, 158));
        endcase
        return {1'($urandom_range(0, 1)), e, 23'($urandom)};
    endfunction

    // Monitor: predicts grants/valid timing, pushes expected results, pops on output handshake
    always @(negedge aclk) begin
        logic [N_REQ-1:0] exp_ready;
        int               win;
        int               idx;
        exp_t             ex;
        if (!aresetn) begin
            sb_q.delete();
            rr_model  = 0;
            cnt_model = 0;
            in_flight = 1'b0;
            chk("rst_m_tvalid", 32'(m_axis_tvalid), 32'd0);
            chk("rst_m_tdata", m_axis_tdata, 32'd0);
            chk("rst_m_tid", 32'(m_axis_tid), 32'd0);
            chk("rst_s_tready", 32'(s_axis_tready), 32'd0);
            chk("rst_busy", 32'(busy), 32'd0);
            chk("rst_done_count", 32'(done_count), 32'd0);
        end else begin
            if (in_flight) since_hs++;
            chk("done_count", 32'(done_count), 32'(cnt_model));
            chk("busy", 32'(busy), 32'(in_flight));
            chk("m_tvalid", 32'(m_axis_tvalid), 32'(in_flight && since_hs >= 2));
            exp_ready = '0;
            win = -1;
            if (!in_flight) begin
                for (int k = 0; k < N_REQ; k++) begin
                    idx = (rr_model + k) % N_REQ;
                    if (win < 0 && s_axis_tvalid[idx]) win = idx;
                end
            end
            if (win >= 0) exp_ready[win] = 1'b1;
            chk("s_tready", 32'(s_axis_tready), 32'(exp_ready));
            if (m_axis_tvalid && m_axis_tready) begin
                if (sb_q.size() == 0) begin
                    chk("sb_unexpected_out", 32'd1, 32'd0);
                end else begin
                    ex = sb_q.pop_front();
                    chk("m_tdata", m_axis_tdata, ex.data);
                    chk("m_tid", 32'(m_axis_tid), 32'(ex.id));
                    rr_model = (ex.id + 1) % N_REQ;
                end
                cnt_model = (cnt_model + 1) % (1 << CNT_W);
                in_flight = 1'b0;
            end else if (win >= 0 && s_axis_tready[win]) begin
                ex.id   = win;
                ex.data = ref_conv(s_axis_tdata[32*win +: 32]);
                sb_q.push_back(ex);
                in_flight = 1'b1;
                since_hs  = 0;
            end
        end
    end

    task automatic send(input int idx, input logic [31:0] f);
        bit ok;
        ok = 1'b0;
        s_axis_tvalid[idx]        = 1'b1;
        s_axis_tdata[32*idx +: 32] = f;
        for (int k = 0; k < 50 && !ok; k++) begin
            @(negedge aclk);
            if (s_axis_tready[idx]) ok = 1'b1;
            @(posedge aclk);
            #1;
        end
        s_axis_tvalid[idx] = 1'b0;
        if (!ok) chk("send_timeout", 32'd0, 32'd1);
    endtask

    // Waits for the result, checks it against a literal, completes the handshake if tready is high
    task automatic expect_out(input string name, input logic [31:0] exp);
        bit ok;
        ok = 1'b0;
        for (int k = 0; k < 20 && !ok; k++) begin
            @(negedge aclk);
            if (m_axis_tvalid) ok = 1'b1;
        end
        if (!ok) chk({name, "_timeout"}, 32'd0, 32'd1);
        else begin
            chk(name, m_axis_tdata, exp);
            chk({name, "_tid"}, 32'(m_axis_tid), 32'd0);
        end
        @(posedge aclk);
        #1;
    endtask

    initial begin
        int seen;
        logic [N_REQ-1:0] hs;
        aresetn       = 1'b0;
        s_axis_tvalid = '0;
        s_axis_tdata  = '0;
        m_axis_tready = 1'b0;
        repeat (3) @(posedge aclk);
        #1 aresetn = 1'b1;

        m_axis_tready = 1'b1;
        send(0, 32'h40490FDB);
        expect_out("t2_pi", 32'd3);
        chk("t2_done_count", 32'(done_count), 32'd1);

        send(0, 32'hC0300000); expect_out("t5_neg_2p75", 32'hFFFF_FFFE);
        send(0, 32'h3F7FFFFF); expect_out("t5_0p99999", 32'd0);
        send(0, 32'h00000001); expect_out("t5_denormal", 32'd0);
        send(0, 32'hCF000000); expect_out("t6_neg_2p31", 32'h8000_0000);
`ifdef FTOI_SATURATE_EN
        send(0, 32'h4F000000); expect_out("t6_2p31_sat", 32'h7FFF_FFFF);
        send(0, 32'h7FC00000); expect_out("t6_nan_sat", 32'd0);
        send(0, 32'hFF800000); expect_out("t6_neg_inf_sat", 32'h8000_0000);
`else
        send(0, 32'h4F000000); expect_out("t6_2p31_wrap", 32'h8000_0000);
        send(0, 32'h7FC00000); expect_out("t6_nan_plain", 32'd0);
`endif

        // Backpressure: result must hold while a competing requester waits
        m_axis_tready = 1'b0;
        send(0, 32'h42280000);
        s_axis_tvalid[2] = 1'b1;
        s_axis_tdata[64 +: 32] = 32'hC1A40000;
        for (int k = 0; k < 20 && !m_axis_tvalid; k++) @(negedge aclk);
        for (int k = 0; k < 10; k++) begin
            @(negedge aclk);
            chk("t4_hold_tdata", m_axis_tdata, 32'd42);
            chk("t4_hold_tid", 32'(m_axis_tid), 32'd0);
            chk("t4_hold_busy", 32'(busy), 32'd1);
            chk("t4_hold_s_tready", 32'(s_axis_tready), 32'd0);
        end
        @(posedge aclk);
        #1 m_axis_tready = 1'b1;
        @(negedge aclk);
        chk("t4_single_hs", 32'(m_axis_tvalid), 32'd1);
        @(negedge aclk);
        chk("t4_tvalid_low", 32'(m_axis_tvalid), 32'd0);
        @(posedge aclk);
        #1;
        send(2, 32'hC1A40000);
        repeat (5) @(posedge aclk);
        #1;

        // Reset mid-OUT drops the beat
        m_axis_tready = 1'b0;
        send(1, 32'h41200000);
        for (int k = 0; k < 20 && !m_axis_tvalid; k++) @(negedge aclk);
        chk("t1_pre_tvalid", 32'(m_axis_tvalid), 32'd1);
        @(posedge aclk);
        #2 aresetn = 1'b0;
        #1;
        chk("t1_tvalid", 32'(m_axis_tvalid), 32'd0);
        chk("t1_tdata", m_axis_tdata, 32'd0);
        chk("t1_busy", 32'(busy), 32'd0);
        chk("t1_done_count", 32'(done_count), 32'd0);
        @(negedge aclk);
        @(posedge aclk);
        #1 aresetn = 1'b1;

        // All requesters valid continuously: grants cycle from index 0
        m_axis_tready = 1'b1;
        s_axis_tdata  = {32'h40800000, 32'h40400000, 32'h40000000, 32'h3F800000};
        s_axis_tvalid = '1;
        seen = 0;
        for (int k = 0; k < 100 && seen < 5; k++) begin
            @(negedge aclk);
            if (m_axis_tvalid && m_axis_tready) begin
                chk("t3_rr_tid", 32'(m_axis_tid), 32'(seen % N_REQ));
                chk("t3_rr_data", m_axis_tdata, 32'((seen % N_REQ) + 1));
                seen++;
            end
        end
        if (seen < 5) chk("t3_timeout", 32'(seen), 32'd5);
        @(posedge aclk);
        #1 s_axis_tvalid = '0;

        // Randomized traffic with random backpressure and occasional withdrawal before grant
        for (int cyc = 0; cyc < 3000; cyc++) begin
            @(negedge aclk);
            hs = s_axis_tvalid & s_axis_tready;
            @(posedge aclk);
            #1;
            m_axis_tready = ($urandom_range(0, 9) < 7);
            for (int i = 0; i < N_REQ; i++) begin
                if (hs[i] || !s_axis_tvalid[i]) begin
                    s_axis_tvalid[i] = 1'($urandom_range(0, 1));
                    s_axis_tdata[32*i +: 32] = rand_float();
                end else if ($urandom_range(0, 19) == 0) begin
                    s_axis_tvalid[i] = 1'b0;
                end
            end
        end
        s_axis_tvalid = '0;
        m_axis_tready = 1'b1;
        repeat (10) @(posedge aclk);
        @(negedge aclk);
        chk("sb_drained", 32'(sb_q.size()), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
